// File: rtl/cdb_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : cdb_arbiter_pkg / cdb_arbiter_if
// Brief  : CDB result record type and the FU-to-CDB bus interface.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cdb_arbiter_pkg;
    localparam int ROB_IDX_W = 6;
    localparam int PREG_W    = 7;
    localparam int AREG_W    = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd_s;
        logic [AREG_W-1:0]    rd_s;
        logic [DATA_W-1:0]    rd_v;
        logic                 valid;
    } cdb_t;
endpackage

interface cdb_arbiter_if #(
    parameter int NUM_FU = 3
);
    cdb_arbiter_pkg::cdb_t fu_cdb [NUM_FU];
    logic [NUM_FU-1:0]     fu_ready;
    cdb_arbiter_pkg::cdb_t cdb_out;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]           perf_conflict_cnt;
    logic [31:0]           perf_full_cnt;

    modport master (output fu_cdb, input fu_ready, input cdb_out,
                    input perf_conflict_cnt, input perf_full_cnt);
    modport slave  (input fu_cdb, output fu_ready, output cdb_out,
                    output perf_conflict_cnt, output perf_full_cnt);
`else
    modport master (output fu_cdb, input fu_ready, input cdb_out);
    modport slave  (input fu_cdb, output fu_ready, output cdb_out);
`endif
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// Module : cdb_arbiter
// Brief  : Round-robin arbiter sharing one registered CDB among the FU result
//          queues. Optional perf counters enabled by CDB_ARB_PERF_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 3,
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] ready;
    cdb_t              head [NUM_FU];
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  rr_ptr_d;
    cdb_t              cdb_out_q;

    //--------------------------------------------------------------------------
    // Per-FU result FIFOs with an empty-queue bypass
    //--------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_t             mem_q [QDEPTH];
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [PTR_W-1:0] rd_ptr_d;
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] wr_ptr_d;
        logic             granted;
        logic             push;

        assign granted  = grant_vld && (grant_idx == IDX_W'(i));
        assign req[i]   = (count_q != '0) || bus.fu_cdb[i].valid;
        assign head[i]  = (count_q != '0) ? mem_q[rd_ptr_q] : bus.fu_cdb[i];
        assign ready[i] = !rst && (count_q != DEPTH_C);

        always_comb begin
            count_d  = count_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            push     = 1'b0;
            if (granted && (count_q != '0)) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_d - CNT_W'(1);
            end
            // A granted bypass consumes the input directly; a full, ungranted
            // queue drops it and keeps its state.
            if (bus.fu_cdb[i].valid && !(granted && (count_q == '0)) &&
                (granted || (count_q != DEPTH_C))) begin
                push     = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_d + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q  <= count_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push && !rst && !flush_i) begin
                mem_q[wr_ptr_q] <= bus.fu_cdb[i];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Round-robin grant, search starting at rr_ptr
    //--------------------------------------------------------------------------
    always_comb begin
        int               cand_i;
        logic [IDX_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand_i = int'(rr_ptr_q) + k;
            if (cand_i >= NUM_FU) begin
                cand_i = cand_i - NUM_FU;
            end
            cand = IDX_W'(cand_i);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            cdb_out_q <= '0;
        end else if (flush_i) begin
            rr_ptr_q        <= '0;
            cdb_out_q.valid <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (grant_vld) begin
                cdb_out_q       <= head[grant_idx];
                cdb_out_q.valid <= 1'b1;
            end else begin
                cdb_out_q.valid <= 1'b0;
            end
        end
    end

    assign bus.cdb_out  = cdb_out_q;
    assign bus.fu_ready = ready;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_full_q;
    logic        multi_req;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi_req = |(req & (req - NUM_FU'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_full_q     <= '0;
        end else begin
            if (!flush_i && multi_req && (perf_conflict_q != '1)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
            if (!(&ready) && (perf_full_q != '1)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign bus.perf_conflict_cnt = perf_conflict_q;
    assign bus.perf_full_cnt     = perf_full_q;
`endif

endmodule

`default_nettype wire
